traffic_controller: RTL and testbench
=====================================

Name: traffic_controller

Overview:
- Two-way (north-south / east-west) intersection traffic-light sequencer.
- A fixed-time Moore FSM cycles NS green, NS yellow, all-red, EW green, EW yellow, all-red, then repeats.
- Phase durations are set by parameters and counted in clock cycles.
- It is a standalone top-level control block with no inputs other than clock and reset.

Parameters:
- GREEN_CYCLES, default 10: clock cycles each green phase lasts; must be ≥1.
- YELLOW_CYCLES, default 5: clock cycles each yellow phase lasts; must be ≥1.
- ALLRED_CYCLES, default 3: clock cycles each all-red clearance phase lasts; must be ≥1.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk.
- ns_light  output  3  north-south lamp, one-hot {red,yellow,green}: 3'b100 red, 3'b010 yellow, 3'b001 green.
- ew_light  output  3  east-west lamp, same encoding.

Behaviour:
- States and lamps, in fixed order:
  - S_NS_GREEN: ns=001, ew=100.
  - S_NS_YELLOW: ns=010, ew=100.
  - S_ALLRED_1: ns=100, ew=100.
  - S_EW_GREEN: ns=100, ew=001.
  - S_EW_YELLOW: ns=100, ew=010.
  - S_ALLRED_2: ns=100, ew=100.
  - After S_ALLRED_2 the FSM returns to S_NS_GREEN.
- Outputs are decoded combinationally from the state register only (Moore). They change in the same cycle the state register updates, with no extra latency.
- Phase timer:
  - Cycle counter, width $clog2(max(G,Y,A)+1), at least 1 bit.
  - On entering a state the counter is 0. It increments each cycle.
  - When counter == duration−1 for the current state, the next edge advances the state and clears the counter. Each state is therefore held exactly its parameter count of cycles.
- Full period is 2*(G+Y+A) cycles; 36 with defaults.
- Reset (rst==0 at a rising edge): state ← S_NS_GREEN, counter ← 0. While held in reset, outputs are ns=001, ew=100.
- Timing after reset release: the first edge with rst==1 is counted as cycle 0 of S_NS_GREEN.
- Reset asserted mid-phase, in any state: the next edge forces S_NS_GREEN/counter 0. The interrupted phase is not completed.
- Safety invariants:
  - ns_light and ew_light are never both non-red.
  - Each output is always exactly one-hot.
  - Green is always followed by yellow, and yellow by all-red.
- Illegal or unused state encodings recover to S_NS_GREEN on the next edge, with counter cleared.
- Durations of 1 are legal: the state lasts a single cycle.

Decomposition:
- Shared package traffic_pkg holds:
  - the state typedef (6-value enum);
  - lamp constants LAMP_RED=3'b100, LAMP_YELLOW=3'b010, LAMP_GREEN=3'b001.
- One natural sub-module, phase_timer. It has parameter WIDTH, inputs clk, rst, load (state-change strobe) and duration, and output done (counter == duration−1).
- The top holds the FSM register, next-state logic, duration mux and lamp decode.

Test Plan:
- Reset hold: rst=0 for 5 cycles -> ns=001, ew=100 throughout; no state advance.
- Full sequence at defaults, after release:
  - ns=001/ew=100 for 10 cycles;
  - ns=010/ew=100 for 5;
  - both 100 for 3;
  - ns=100/ew=001 for 10;
  - ns=100/ew=010 for 5;
  - both 100 for 3;
  - then NS green again at cycle 36.
- Periodicity: run 108 cycles -> exactly 3 identical periods. Each lamp is green 30 cycles total per lamp.
- Safety check: every cycle of a 500-cycle run -> both outputs one-hot; never ns≠100 and ew≠100 simultaneously.
- Mid-phase reset: assert rst=0 for 1 cycle at cycle 3 of EW_YELLOW -> next cycle ns=001/ew=100, followed by a full 10-cycle NS green.
- Minimum durations: G=Y=A=1 -> each of the 6 states lasts 1 cycle; period 6; invariants hold.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-way intersection light sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALLRED_1  = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALLRED_2  = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..max_count, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: cleared on reset or phase change, flags the last cycle of a phase.
module phase_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] duration,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || load) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign done = (cnt == (duration - WIDTH'(1)));

endmodule

// File: rtl/traffic_controller.sv
// Fixed-time NS/EW intersection sequencer: green, yellow, all-red for each direction in turn.
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_CYCLES  = 10,
  parameter int unsigned YELLOW_CYCLES = 5,
  parameter int unsigned ALLRED_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light
);

  localparam int unsigned CNT_W = cnt_width(max3(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES));

  state_t           state;
  state_t           state_next_c;
  logic [CNT_W-1:0] duration_c;
  logic             load_c;
  logic             done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_NS_GREEN;
    end else begin
      state <= state_next_c;
    end
  end

  // Length of the phase currently held.
  always_comb begin
    duration_c = CNT_W'(GREEN_CYCLES);
    case (state)
      S_NS_YELLOW, S_EW_YELLOW: duration_c = CNT_W'(YELLOW_CYCLES);
      S_ALLRED_1, S_ALLRED_2:   duration_c = CNT_W'(ALLRED_CYCLES);
      default:                  duration_c = CNT_W'(GREEN_CYCLES);
    endcase
  end

  // Advance on the last cycle of a phase; unused encodings fall back to NS green.
  always_comb begin
    state_next_c = state;
    case (state)
      S_NS_GREEN:  if (done) state_next_c = S_NS_YELLOW;
      S_NS_YELLOW: if (done) state_next_c = S_ALLRED_1;
      S_ALLRED_1:  if (done) state_next_c = S_EW_GREEN;
      S_EW_GREEN:  if (done) state_next_c = S_EW_YELLOW;
      S_EW_YELLOW: if (done) state_next_c = S_ALLRED_2;
      S_ALLRED_2:  if (done) state_next_c = S_NS_GREEN;
      default:     state_next_c = S_NS_GREEN;
    endcase
  end

  // Any state change restarts the phase count, including recovery from a bad encoding.
  assign load_c = (state_next_c != state);

  phase_timer #(
    .WIDTH(CNT_W)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .duration(duration_c),
    .done    (done)
  );

  // Moore lamp decode; an unused encoding shows the reset lamps so outputs stay one-hot.
  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    case (state)
      S_NS_GREEN:  ns_light = LAMP_GREEN;
      S_NS_YELLOW: ns_light = LAMP_YELLOW;
      S_ALLRED_1:  ns_light = LAMP_RED;
      S_EW_GREEN:  ew_light = LAMP_GREEN;
      S_EW_YELLOW: ew_light = LAMP_YELLOW;
      S_ALLRED_2:  ew_light = LAMP_RED;
      default:     ns_light = LAMP_GREEN;
    endcase
  end

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller: default and minimum-duration instances against a timeline model.
module tb_traffic_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] ns_min;
  logic [2:0] ew_min;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned k           = 0;
  int unsigned ns_green    = 0;
  int unsigned ew_green    = 0;

  always #5 clk = ~clk;

  traffic_controller dut (
    .clk     (clk),
    .rst     (rst),
    .ns_light(ns_light),
    .ew_light(ew_light)
  );

  traffic_controller #(
    .GREEN_CYCLES (1),
    .YELLOW_CYCLES(1),
    .ALLRED_CYCLES(1)
  ) dut_min (
    .clk     (clk),
    .rst     (rst),
    .ns_light(ns_min),
    .ew_light(ew_min)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Lamps {ns,ew} k edges into a fresh cycle: walk the phase table from the start of the period.
  function automatic logic [5:0] ref_lamps(input int unsigned kk, input int unsigned g,
                                           input int unsigned y, input int unsigned a);
    int unsigned dur[6];
    logic [5:0]  lamps[6];
    int unsigned p;
    dur   = '{g, y, a, g, y, a};
    lamps = '{6'b001_100, 6'b010_100, 6'b100_100, 6'b100_001, 6'b100_010, 6'b100_100};
    p = kk % (2 * (g + y + a));
    for (int i = 0; i < 6; i++) begin
      if (p < dur[i]) return lamps[i];
      p = p - dur[i];
    end
    return 6'b000_000;
  endfunction

  task automatic check_all();
    logic [5:0] e;
    logic [5:0] em;
    e  = ref_lamps(k, 10, 5, 3);
    em = ref_lamps(k, 1, 1, 1);
    check_val("ns", 32'(ns_light), 32'(e[5:3]));
    check_val("ew", 32'(ew_light), 32'(e[2:0]));
    check_val("ns_min", 32'(ns_min), 32'(em[5:3]));
    check_val("ew_min", 32'(ew_min), 32'(em[2:0]));
    check_val("onehot", 32'({$onehot(ns_light), $onehot(ew_light),
                             $onehot(ns_min), $onehot(ew_min)}), 32'hF);
    check_val("conflict", 32'({(ns_light == 3'b100) || (ew_light == 3'b100),
                               (ns_min == 3'b100) || (ew_min == 3'b100)}), 32'h3);
    if (ns_light == 3'b001) ns_green++;
    if (ew_light == 3'b001) ew_green++;
  endtask

  // One clock: advance the model by the reset level seen at the edge, then sample.
  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    if (!r) k = 0;
    else    k++;
    #1;
    check_all();
  endtask

  initial begin
    int unsigned guard;
    int unsigned run;

    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Three full periods after release.
    rst = 1'b1;
    ns_green = 0;
    ew_green = 0;
    for (int i = 0; i < 108; i++) step();
    check_val("ns_green_108", ns_green, 30);
    check_val("ew_green_108", ew_green, 30);

    // Reach cycle 3 of EW yellow, then pulse reset for one edge.
    guard = 0;
    while ((k % 36) != 31 && guard < 40) begin
      step();
      guard++;
    end
    check_val("reach_ew_yellow", 32'(k % 36), 31);
    check_val("ew_yellow_lamp", 32'(ew_light), 32'h2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    run = 0;
    guard = 0;
    while (ns_light == 3'b001 && guard < 20) begin
      run++;
      step();
      guard++;
    end
    check_val("ns_green_run_after_reset", run, 10);
    check_val("ns_yellow_after_green", 32'(ns_light), 32'h2);

    // Random reset pulses over a long run.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 39) != 0);
      step();
    end
    rst = 1'b1;
    for (int i = 0; i < 40; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
